// File: rtl/dac_start_sequencer.sv
`timescale 1ns/1ps
// dac_start_sequencer
// -------------------
// Multi-channel DAC start gate in the DAC clock domain. Once the host arms it
// (start low->high), it waits for a rising edge on trigger, waits a latched
// number of cycles, then drives the latched channel mask onto dac_start.
// Continuous mode (mode=0) holds the mask until start drops. Burst mode
// (mode=1) ends after burst_len further trigger edges (0 behaves as 1). In
// burst mode it then parks in HOLD until start drops.
//
// Ports
//   clk          DAC clock, rising edge
//   reset        asynchronous, active-high
//   start        host start level (synchronous to clk); low aborts any state
//   trigger      trigger level (synchronous to clk); only rising edges act
//   ch_enable    channel mask, latched on arm
//   delay        trigger-edge to dac_start delay in cycles, latched on arm
//   mode         0 = continuous, 1 = burst, latched on arm
//   burst_len    trigger edges per burst (0 behaves as 1), latched on arm
//   dac_start    per-channel start, registered
//   busy         high in every state except IDLE, registered
//   done         one-cycle pulse when a burst completes, registered
//   trig_count   trigger edges counted in RUN, saturating, registered
//   o_dbg_state  current FSM state, for debug and checkers
//
// Control protocol: start is a level. Raising it arms the block and
// lowering it returns the block to IDLE on the next clock, whatever else
// happens in that cycle. trigger acts only on a 0->1 transition between two
// consecutive clock samples. There is no valid/ready handshake.
module dac_start_sequencer #(
  parameter int N_CH    = 4,
  parameter int DELAY_W = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               trigger,
  input  logic [N_CH-1:0]    ch_enable,
  input  logic [DELAY_W-1:0] delay,
  input  logic               mode,
  input  logic [COUNT_W-1:0] burst_len,
  output logic [N_CH-1:0]    dac_start,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] trig_count,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_RUN   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_trig_d;
  logic [N_CH-1:0]    r_mask;
  logic [DELAY_W-1:0] r_delay;
  logic               r_mode;
  logic [COUNT_W-1:0] r_burst_len;
  logic [DELAY_W-1:0] r_delay_cnt;
  logic [N_CH-1:0]    r_dac_start;
  logic               r_busy;
  logic               r_done;
  logic [COUNT_W-1:0] r_trig_count;

  logic               w_edge;
  logic [COUNT_W-1:0] w_count_next;
  logic [COUNT_W-1:0] w_burst_eff;
  logic               w_burst_hit;

  assign w_edge       = trigger & ~r_trig_d;
  // Saturating increment: the counter never wraps back to zero.
  assign w_count_next = (r_trig_count == '1) ? r_trig_count
                                             : r_trig_count + COUNT_W'(1);
  // A programmed length of zero behaves as a single-edge burst.
  assign w_burst_eff  = (r_burst_len == '0) ? COUNT_W'(1) : r_burst_len;
  assign w_burst_hit  = r_mode && (w_count_next == w_burst_eff);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_trig_d     <= 1'b0;
      r_mask       <= '0;
      r_delay      <= '0;
      r_mode       <= 1'b0;
      r_burst_len  <= '0;
      r_delay_cnt  <= '0;
      r_dac_start  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_trig_count <= '0;
    end else begin
      r_trig_d <= trigger;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dac_start <= '0;
          r_busy      <= 1'b0;
          if (start) begin
            r_mask       <= ch_enable;
            r_delay      <= delay;
            r_mode       <= mode;
            r_burst_len  <= burst_len;
            r_trig_count <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_edge) begin
            if (r_delay == '0) begin
              r_dac_start <= r_mask;
              r_state     <= S_RUN;
            end else begin
              r_delay_cnt <= r_delay;
              r_state     <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          // Trigger edges are deliberately ignored while counting down.
          if (!start) begin
            r_busy      <= 1'b0;
            r_delay_cnt <= '0;
            r_state     <= S_IDLE;
          end else if (r_delay_cnt == DELAY_W'(1)) begin
            r_delay_cnt <= '0;
            r_dac_start <= r_mask;
            r_state     <= S_RUN;
          end else begin
            r_delay_cnt <= r_delay_cnt - DELAY_W'(1);
          end
        end
        S_RUN: begin
          if (!start) begin
            r_dac_start <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_edge) begin
            r_trig_count <= w_count_next;
            if (w_burst_hit) begin
              r_dac_start <= '0;
              r_done      <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Parked until the host drops start; no re-arm from here.
          r_dac_start <= '0;
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_dac_start <= '0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign dac_start   = r_dac_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign trig_count  = r_trig_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dac_start_sequencer.sv
`timescale 1ns/1ps
module tb_dac_start_sequencer;
  localparam int L = 48;

  logic        clk = 1'b0;
  logic        reset, start, trigger, mode;
  logic [3:0]  ch_enable;
  logic [15:0] delay, burst_len;
  logic [3:0]  dac_start;
  logic        busy, done;
  logic [15:0] trig_count;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dac_start_sequencer #(.N_CH(4), .DELAY_W(16), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .trigger(trigger),
    .ch_enable(ch_enable), .delay(delay), .mode(mode), .burst_len(burst_len),
    .dac_start(dac_start), .busy(busy), .done(done), .trig_count(trig_count),
    .o_dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Inputs set after step() are sampled at the next rising edge; outputs read
  // after step() reflect the rising edge just passed.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    start = 1'b0; trigger = 1'b0;
    repeat (n) step();
  endtask

  task automatic arm(input logic [3:0] m, input int d, input logic md, input int bl);
    ch_enable = m; delay = 16'(d); mode = md; burst_len = 16'(bl); start = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; trigger = 1'b0; ch_enable = '0;
    delay = '0; mode = 1'b0; burst_len = '0;
    #12;
    checks++; if (dac_start !== 4'd0) begin failures++; $display("FAIL rst_dac: got %b expected 0000", dac_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (trig_count !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", trig_count); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    @(negedge clk); reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_continuous();
    idle(2);
    arm(4'b1011, 0, 1'b0, 5);
    ch_enable = 4'b0100; delay = 16'd9; mode = 1'b1; // post-arm changes must not matter
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cont_busy_arm: got %b expected 1", busy); end
    trigger = 1'b1; step();
    checks++; if (dac_start !== 4'b1011) begin failures++; $display("FAIL cont_dac_rise: got %b expected 1011", dac_start); end
    for (int i = 0; i < 6; i++) begin
      trigger = (i % 2 == 1);
      step();
      checks++;
      if (dac_start !== 4'b1011 || done !== 1'b0) begin
        failures++; $display("FAIL cont_hold: got dac=%b done=%b expected dac=1011 done=0", dac_start, done);
      end
    end
    start = 1'b0; trigger = 1'b0; step();
    checks++;
    if (dac_start !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL cont_stop: got dac=%b busy=%b done=%b expected 0000 0 0", dac_start, busy, done);
    end
  endtask

  task automatic test_delay();
    logic [3:0] exp_dac;
    idle(2);
    arm(4'b0001, 5, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      trigger = (i == 0 || i == 3); // entry edge at T, ignored edge at T+3
      step();                       // observing cycle T+i+1
      exp_dac = (i + 1 >= 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (dac_start !== exp_dac || trig_count !== 16'd0) begin
        failures++; $display("FAIL delay_t%0d: got dac=%b count=%0d expected dac=%b count=0", i + 1, dac_start, trig_count, exp_dac);
      end
    end
    start = 1'b0; trigger = 1'b0; step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL delay_stop: got busy=%b expected 0", busy); end
  endtask

  task automatic test_burst();
    int c;
    logic [3:0] exp_dac; logic exp_done; logic [15:0] exp_cnt;
    idle(2);
    arm(4'b1111, 0, 1'b1, 3);
    for (int i = 0; i < 12; i++) begin
      trigger = (i % 2 == 0) && (i <= 10); // entry at 0, counted 2,4,6, then 8,10 in HOLD
      step();
      c = i + 1;
      exp_dac  = (c >= 1 && c <= 6) ? 4'b1111 : 4'b0000;
      exp_done = (c == 7);
      exp_cnt  = 16'((c > 2) + (c > 4) + (c > 6));
      checks++;
      if (dac_start !== exp_dac || done !== exp_done || trig_count !== exp_cnt || busy !== 1'b1) begin
        failures++;
        $display("FAIL burst_t%0d: got dac=%b done=%b count=%0d busy=%b expected dac=%b done=%b count=%0d busy=1",
                 c, dac_start, done, trig_count, busy, exp_dac, exp_done, exp_cnt);
      end
    end
    start = 1'b0; trigger = 1'b0; step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_release: got busy=%b expected 0", busy); end
  endtask

  task automatic test_burst_len0();
    int c;
    logic [3:0] exp_dac;
    idle(2);
    arm(4'b0110, 0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      trigger = (i == 0 || i == 2);
      step();
      c = i + 1;
      exp_dac = (c <= 2) ? 4'b0110 : 4'b0000;
      checks++;
      if (dac_start !== exp_dac || done !== (c == 3) || trig_count !== 16'(c > 2)) begin
        failures++;
        $display("FAIL len0_t%0d: got dac=%b done=%b count=%0d expected dac=%b done=%b count=%0d",
                 c, dac_start, done, trig_count, exp_dac, (c == 3), (c > 2));
      end
    end
    idle(2);
    arm(4'b0110, 0, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      trigger = (i == 0 || i == 2);
      start   = (i < 2); // start drops on the completing edge
      step();
      c = i + 1;
      exp_dac = (c <= 2) ? 4'b0110 : 4'b0000;
      checks++;
      if (dac_start !== exp_dac || done !== 1'b0 || busy !== (c <= 2)) begin
        failures++;
        $display("FAIL len0_abort_t%0d: got dac=%b done=%b busy=%b expected dac=%b done=0 busy=%b",
                 c, dac_start, done, busy, exp_dac, (c <= 2));
      end
    end
  endtask

  task automatic test_async_reset();
    idle(2);
    arm(4'b1111, 10, 1'b0, 0);
    trigger = 1'b1; step(); trigger = 1'b0; step(); step();
    checks++; if (busy !== 1'b1 || dac_start !== 4'd0) begin failures++; $display("FAIL ar_delay_pre: got busy=%b dac=%b expected 1 0000", busy, dac_start); end
    #2; reset = 1'b1; start = 1'b0; #1;
    checks++;
    if (dac_start !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || trig_count !== 16'd0) begin
      failures++; $display("FAIL ar_delay: got dac=%b busy=%b done=%b count=%0d expected all 0", dac_start, busy, done, trig_count);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      trigger = (i % 3 == 0);
      step();
      checks++;
      if (dac_start !== 4'd0 || busy !== 1'b0) begin
        failures++; $display("FAIL ar_delay_after: got dac=%b busy=%b expected 0000 0", dac_start, busy);
      end
    end
    idle(2);
    arm(4'b1111, 0, 1'b0, 0);
    trigger = 1'b1; step(); trigger = 1'b0; step();
    checks++; if (dac_start !== 4'b1111) begin failures++; $display("FAIL ar_run_pre: got %b expected 1111", dac_start); end
    trigger = 1'b1; step();
    checks++; if (trig_count !== 16'd1) begin failures++; $display("FAIL ar_run_count: got %0d expected 1", trig_count); end
    #2; reset = 1'b1; start = 1'b0; trigger = 1'b0; #1;
    checks++;
    if (dac_start !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || trig_count !== 16'd0) begin
      failures++; $display("FAIL ar_run: got dac=%b busy=%b done=%b count=%0d expected all 0", dac_start, busy, done, trig_count);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      trigger = (i % 2 == 0);
      step();
      checks++;
      if (dac_start !== 4'd0) begin failures++; $display("FAIL ar_run_after: got dac=%b expected 0000", dac_start); end
    end
  endtask

  task automatic test_trigger_held();
    idle(2);
    trigger = 1'b1; step();
    arm(4'b0101, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy !== 1'b1 || dac_start !== 4'd0) begin
        failures++; $display("FAIL held_armed: got busy=%b dac=%b expected 1 0000", busy, dac_start);
      end
    end
    trigger = 1'b0; step();
    trigger = 1'b1; step();
    checks++; if (dac_start !== 4'b0101) begin failures++; $display("FAIL held_restart: got %b expected 0101", dac_start); end
    idle(2);
  endtask

  // Random single-arm trials against a timeline model: the first trigger edge
  // after arming starts the window, the mask appears delay cycles later, and
  // counted edges are those from that point until start drops or the burst ends.
  task automatic test_random(input int trials);
    logic        tr [0:L-1];
    logic        st [0:L-1];
    logic [21:0] exp_q[$];
    logic [21:0] exp;
    for (int t = 0; t < trials; t++) begin
      int a, s, e, rs, b, d, eff, cnt;
      logic md, ran;
      logic [3:0] mk;
      logic [15:0] bl;
      a  = $urandom_range(1, 4);
      s  = $urandom_range(a + 1, L + 4);
      d  = $urandom_range(0, 6);
      mk = 4'($urandom_range(0, 15));
      md = 1'($urandom_range(0, 1));
      bl = 16'($urandom_range(0, 4));
      eff = (bl == 16'd0) ? 1 : int'(bl);
      for (int c = 0; c < L; c++) begin
        st[c] = (c >= a) && (c < s);
        tr[c] = (c == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      end
      e = -1;
      for (int k = a + 1; k < L && k < s; k++)
        if (tr[k] && !tr[k-1]) begin e = k; break; end
      rs  = (e >= 0) ? e + 1 + d : 1 << 20;
      ran = (e >= 0) && (rs <= s);
      b   = 1 << 20;
      cnt = 0;
      if (ran)
        for (int k = rs; k < L && k < s; k++)
          if (tr[k] && !tr[k-1]) begin
            cnt++;
            if (md && cnt == eff) begin b = k; break; end
          end
      for (int c = 1; c <= L; c++) begin
        logic bz, dn;
        logic [3:0] dv;
        int tc;
        bz = (c >= a + 1) && (c <= s);
        dv = (ran && c >= rs && c <= s && c <= b) ? mk : 4'd0;
        dn = (b < (1 << 20)) && (c == b + 1);
        tc = 0;
        if (ran)
          for (int k = rs; k < c && k < s && k <= b && k < L; k++)
            if (tr[k] && !tr[k-1]) tc++;
        exp_q.push_back({bz, dn, dv, 16'(tc)});
      end
      for (int c = 0; c < L; c++) begin
        start = st[c]; trigger = tr[c];
        if (c == a) begin
          ch_enable = mk; delay = 16'(d); mode = md; burst_len = bl;
        end else begin
          ch_enable = 4'($urandom_range(0, 15)); delay = 16'($urandom_range(0, 6));
          mode = 1'($urandom_range(0, 1)); burst_len = 16'($urandom_range(0, 4));
        end
        step();
        exp = exp_q.pop_front();
        checks++;
        if (busy !== exp[21] || done !== exp[20] || dac_start !== exp[19:16]) begin
          failures++;
          $display("FAIL rand_t%0d_c%0d: got busy=%b done=%b dac=%b expected busy=%b done=%b dac=%b",
                   t, c + 1, busy, done, dac_start, exp[21], exp[20], exp[19:16]);
        end
        if (c + 1 >= a + 1) begin
          checks++;
          if (trig_count !== exp[15:0]) begin
            failures++; $display("FAIL rand_count_t%0d_c%0d: got %0d expected %0d", t, c + 1, trig_count, exp[15:0]);
          end
        end
      end
      idle(3);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_continuous();
    test_delay();
    test_burst();
    test_burst_len0();
    test_async_reset();
    test_trigger_held();
    test_random(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_start_sequencer.md
# dac_start_sequencer

Multi-channel, parametrised successor to the single-channel DAC start gate. It sits in the DAC clock domain between the host start/trigger logic and the per-channel DAC writers. When the host arms it, it waits for a rising edge on the trigger (normally the integrator reset pulse) and then waits a programmable delay. It then raises a per-channel `dac_start` mask, either until the host drops `start` (continuous mode) or for a programmed number of trigger edges (burst mode).

## Interface
- `N_CH`, 4, number of DAC channels
- `DELAY_W`, 16, width of trigger-to-start delay
- `COUNT_W`, 16, width of burst length and trigger counter
- `clk`  in  1  DAC clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `start`  in  1  host start level, already synced to `clk`
- `trigger`  in  1  trigger level, already synced to `clk`; only rising edges act
- `ch_enable`  in  N_CH  channel mask, latched on arm
- `delay`  in  DELAY_W  cycles from trigger edge to `dac_start`, latched on arm
- `mode`  in  1  0 = continuous, 1 = burst; latched on arm
- `burst_len`  in  COUNT_W  trigger edges per burst; 0 treated as 1; latched on arm
- `dac_start`  out  N_CH  per-channel start, registered
- `busy`  out  1  high in any state other than IDLE, registered
- `done`  out  1  one-cycle pulse when a burst completes, registered
- `trig_count`  out  COUNT_W  trigger edges counted while in RUN, registered

## Operation
- Edge detect: `trig_d` register holds the previous `trigger`, reset 0. `edge = trigger & ~trig_d`.
- States: IDLE, ARMED, DELAY, RUN, HOLD. Reset state is IDLE.
- Reset values: `dac_start`=0, `busy`=0, `done`=0, `trig_count`=0, delay counter=0, latched config=0.
- IDLE: outputs low.
  - `start`=1 → ARMED.
  - On this transition, latch `ch_enable`, `delay`, `mode`, `burst_len` and clear `trig_count`.
- ARMED: on `edge`, go to RUN if latched delay = 0, otherwise go to DELAY and load the counter with the latched delay.
- DELAY: the counter decrements each cycle. When the counter = 1, go to RUN.
- RUN: `dac_start` = latched mask.
  - Each `edge` in RUN increments `trig_count`, saturating at all-ones. The edge that triggered entry does not count.
  - Mode 0: stay in RUN until `start`=0.
  - Mode 1: on the edge that makes `trig_count` equal the effective burst length, go to HOLD and pulse `done`.
- HOLD: `dac_start`=0 and `busy`=1. Wait for `start`=0, then go to IDLE. There is no re-arm without a `start` low→high cycle.
- Priority: `start`=0 in ARMED, DELAY, RUN or HOLD → IDLE next cycle. This overrides a same-cycle `edge` and burst completion, and `done` does not pulse.
- Config inputs changing after arm have no effect until the next arm.
- Edges arriving in DELAY are ignored and not counted.
- A latched mask of all-zero still runs the FSM; `dac_start` stays 0.
- An asynchronous `reset` mid-operation returns to IDLE immediately with all outputs at their reset values.

## Timing
- Edge at cycle T means `trigger` was sampled 1 at T and 0 at T-1.
- `dac_start` is high from cycle T+1+delay, with delay as latched.
- `start` sampled low at cycle S → `dac_start`=0 and `busy`=0 from S+1.
- Burst completing edge at cycle B:
  - `dac_start`=0 and `done`=1 at B+1.
  - `done`=0 at B+2.
  - `trig_count` = burst length at B+1 and holds until the next arm.
- `start` rising at A: `busy`=1 from A+1. The earliest usable edge is at A+1.
- All outputs come straight from registers; there are no combinational paths from input to output.

## Test plan
- Continuous, delay 0, mask 4'b1011:
  - arm, trigger edge at T → `dac_start`=1011 at T+1.
  - drop `start` at S → 0000 at S+1; `done` never pulses.
- Delay 5, mask 4'b0001:
  - edge at T → `dac_start` rises at T+6.
  - second edge at T+3 is ignored; `trig_count` stays 0.
- Burst, burst_len 3:
  - entry edge, then edges at R1, R2, R3 in RUN.
  - `dac_start` falls and `done` pulses at R3+1; `trig_count`=3.
  - `start` held high → remains in HOLD with `busy`=1; no re-arm on later edges.
- burst_len 0:
  - behaves as 1; `done` follows the first counted edge.
  - drop `start` on the same cycle as the completing edge → IDLE, no `done` pulse.
- Asynchronous `reset` asserted mid-DELAY and mid-RUN between clock edges:
  - all outputs read 0 before the next `clk` edge.
  - after release, no `dac_start` without a fresh arm and edge.
- `trigger` held high across arm (no low sample after arm) → no edge, stays ARMED. A low-then-high sequence then starts normally.
